// File: rtl/game_stage_controller.sv
// ---------------------------------------------------------------------------
// game_stage_controller
//
// Game-level sequencer: IDLE -> LOAD -> PLAY -> CLEAR -> (LOAD | WON), with
// PLAY -> LOST on player death. It drives the stage number, the motion
// enable, and a per-stage synchronous reset back into the monster and
// player blocks, and it keeps a saturating score.
//
// Optional feature macro: GAME_STAGE_CONTROLLER_LIVES_EN
//   defined   : player death costs a life and reloads the stage; the last
//               life goes to LOST.
//   undefined : player death goes straight to LOST; lives is fixed at 1.
//
// Ports
//   clk                 clock
//   resetN              asynchronous active-low reset
//   startOfFrame        one-cycle pulse per video frame
//   start_key           level; only the rising edge is used
//   all_monsters_dead   level from the monster block
//   monster_died_pulse  high on each cycle a monster's hit state changes
//   player_dead         level from the player block
//   stage_num [2:0]     current stage, 0 when idle
//   enable              gates monster / player motion (high in PLAY)
//   stage_resetN        active-low synchronous reset pulse issued in LOAD
//   score [11:0]        saturating score
//   lives [1:0]         remaining lives
//   game_won            high in WON
//   game_over           high in LOST
// ---------------------------------------------------------------------------
module game_stage_controller #(
    parameter int LAST_STAGE         = 4,
    parameter int STAGE_RESET_CYCLES = 2,
    parameter int INTERSTAGE_FRAMES  = 60,
    parameter int POINTS_PER_KILL    = 10,
    parameter int INITIAL_LIVES      = 3
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start_key,
    input  logic        all_monsters_dead,
    input  logic        monster_died_pulse,
    input  logic        player_dead,
    output logic [2:0]  stage_num,
    output logic        enable,
    output logic        stage_resetN,
    output logic [11:0] score,
    output logic [1:0]  lives,
    output logic        game_won,
    output logic        game_over
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_WON   = 3'd4;
    localparam logic [2:0] S_LOST  = 3'd5;

    localparam logic [2:0]  LAST_STG   = 3'(LAST_STAGE);
    localparam logic [3:0]  RST_LAST   = 4'(STAGE_RESET_CYCLES - 1);
    localparam logic [7:0]  FRM_LAST   = 8'(INTERSTAGE_FRAMES - 1);
    localparam logic [12:0] KILL_PTS   = 13'(POINTS_PER_KILL);
    localparam logic [12:0] SCORE_MAX  = 13'd4095;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_start_prev;
    logic        r_armed;
    logic        r_entry;
    logic [7:0]  r_frame_cnt;
    logic [3:0]  r_rst_cnt;
    logic [2:0]  r_stage;
    logic        r_enable;
    logic        r_stage_resetN;
    logic [11:0] r_score;
    logic        r_won;
    logic        r_over;
    logic        w_start_rise;
    logic        w_state_chg;
    logic [12:0] w_score_sum;
    logic [11:0] w_score_sat;

    assign w_start_rise = start_key & ~r_start_prev;
    assign w_state_chg  = (w_next != r_state);
    assign w_score_sum  = {1'b0, r_score} + KILL_PTS;
    assign w_score_sat  = (w_score_sum > SCORE_MAX) ? 12'hFFF : w_score_sum[11:0];

`ifdef GAME_STAGE_CONTROLLER_LIVES_EN
    logic [1:0] r_lives;
    assign lives = r_lives;
`else
    assign lives = 2'd1;
`endif

    // Every transition changes state, so w_state_chg doubles as the
    // "state entry" strobe used to clear the counters.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_rise) w_next = S_LOAD;
            // Frames are only honoured once the stage reset pulse is done.
            S_LOAD:  if (r_stage_resetN && startOfFrame) w_next = S_PLAY;
            S_PLAY: begin
                if (player_dead) begin
`ifdef GAME_STAGE_CONTROLLER_LIVES_EN
                    w_next = (r_lives > 2'd1) ? S_LOAD : S_LOST;
`else
                    w_next = S_LOST;
`endif
                end else if (all_monsters_dead && r_armed) begin
                    w_next = S_CLEAR;
                end
            end
            // A frame pulse on the first CLEAR cycle is not counted.
            S_CLEAR: if (startOfFrame && !r_entry && r_frame_cnt == FRM_LAST)
                         w_next = (r_stage == LAST_STG) ? S_WON : S_LOAD;
            S_WON,
            S_LOST:  if (w_start_rise) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= S_IDLE;
            r_start_prev   <= 1'b1;   // key held through reset must not start a game
            r_armed        <= 1'b0;
            r_entry        <= 1'b0;
            r_frame_cnt    <= '0;
            r_rst_cnt      <= '0;
            r_stage        <= '0;
            r_enable       <= 1'b0;
            r_stage_resetN <= 1'b1;
            r_score        <= '0;
            r_won          <= 1'b0;
            r_over         <= 1'b0;
`ifdef GAME_STAGE_CONTROLLER_LIVES_EN
            r_lives        <= 2'(INITIAL_LIVES);
`endif
        end else begin
            r_state      <= w_next;
            r_start_prev <= start_key;
            r_entry      <= w_state_chg;
            r_enable     <= (w_next == S_PLAY);
            r_won        <= (w_next == S_WON);
            r_over       <= (w_next == S_LOST);

            if (w_state_chg) begin
                r_frame_cnt <= '0;
                r_rst_cnt   <= '0;
                r_armed     <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD:  if (!r_stage_resetN) r_rst_cnt <= r_rst_cnt + 4'd1;
                    S_PLAY:  if (startOfFrame) r_armed <= 1'b1;
                    S_CLEAR: if (startOfFrame && !r_entry) r_frame_cnt <= r_frame_cnt + 8'd1;
                    default: ;
                endcase
            end

            // Stage reset: low from the first LOAD cycle for STAGE_RESET_CYCLES.
            if (w_next == S_LOAD && r_state != S_LOAD)
                r_stage_resetN <= 1'b0;
            else if (r_state == S_LOAD && !r_stage_resetN && r_rst_cnt == RST_LAST)
                r_stage_resetN <= 1'b1;

            if (r_state == S_IDLE && w_next == S_LOAD)
                r_stage <= 3'd1;
            else if (r_state == S_CLEAR && w_next == S_LOAD)
                r_stage <= r_stage + 3'd1;
            else if (w_next == S_IDLE && r_state != S_IDLE)
                r_stage <= '0;

            if (r_state == S_IDLE && w_next == S_LOAD)
                r_score <= '0;
            else if (r_state == S_PLAY && monster_died_pulse)
                r_score <= w_score_sat;

`ifdef GAME_STAGE_CONTROLLER_LIVES_EN
            if (r_state == S_IDLE && w_next == S_LOAD)
                r_lives <= 2'(INITIAL_LIVES);
            else if (r_state == S_PLAY && player_dead)
                r_lives <= r_lives - 2'd1;   // 1 -> 0 on the fatal death
`endif
        end
    end

    assign stage_num    = r_stage;
    assign enable       = r_enable;
    assign stage_resetN = r_stage_resetN;
    assign score        = r_score;
    assign game_won     = r_won;
    assign game_over    = r_over;

endmodule

// File: tb/tb_game_stage_controller.sv
// ---------------------------------------------------------------------------
// tb_game_stage_controller
//
// Self-checking bench for game_stage_controller with default parameters.
// Score expectations come from a bench-side model pushed into a queue as
// kill pulses are driven and popped when the registered score is sampled.
// The lives scenario runs only when GAME_STAGE_CONTROLLER_LIVES_EN is set.
// ---------------------------------------------------------------------------
module tb_game_stage_controller;

    logic        clk;
    logic        resetN;
    logic        sof;
    logic        start_key;
    logic        amd;
    logic        died;
    logic        pd;
    logic [2:0]  stage_num;
    logic        enable;
    logic        stage_resetN;
    logic [11:0] score;
    logic [1:0]  lives;
    logic        game_won;
    logic        game_over;

    int n_cmp = 0;
    int n_bad = 0;
    int m_score = 0;
    int q_score[$];

`ifdef GAME_STAGE_CONTROLLER_LIVES_EN
    localparam logic [1:0] RESET_LIVES = 2'd3;
`else
    localparam logic [1:0] RESET_LIVES = 2'd1;
`endif

    game_stage_controller dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (sof),
        .start_key          (start_key),
        .all_monsters_dead  (amd),
        .monster_died_pulse (died),
        .player_dead        (pd),
        .stage_num          (stage_num),
        .enable             (enable),
        .stage_resetN       (stage_resetN),
        .score              (score),
        .lives              (lives),
        .game_won           (game_won),
        .game_over          (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    // From PLAY: arm, clear, count 60 frames. Leaves DUT on first cycle after CLEAR exit.
    task automatic play_and_clear();
        pulse_sof();
        amd = 1'b1;
        tick();
        amd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            pulse_sof();
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; start_key = 1'b1;
        tick();
        n_cmp++; if (stage_num !== 3'd0) begin n_bad++; $display("FAIL rst_stage: got %0d want 0", stage_num); end
        n_cmp++; if (enable !== 1'b0) begin n_bad++; $display("FAIL rst_enable: got %0b want 0", enable); end
        n_cmp++; if (stage_resetN !== 1'b1) begin n_bad++; $display("FAIL rst_stage_resetN: got %0b want 1", stage_resetN); end
        n_cmp++; if (score !== 12'd0) begin n_bad++; $display("FAIL rst_score: got %0d want 0", score); end
        n_cmp++; if (lives !== RESET_LIVES) begin n_bad++; $display("FAIL rst_lives: got %0d want %0d", lives, RESET_LIVES); end
        n_cmp++; if (game_won !== 1'b0 || game_over !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got won=%0b over=%0b want 0/0", game_won, game_over); end
        resetN = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (stage_num !== 3'd0 || stage_resetN !== 1'b1) begin n_bad++; $display("FAIL held_key_start: got stage=%0d srn=%0b want 0/1", stage_num, stage_resetN); end
        start_key = 1'b0;
        tick();
    endtask

    task automatic test_start_load();
        int exp;
        start_key = 1'b1;
        tick();
        n_cmp++; if (stage_num !== 3'd1) begin n_bad++; $display("FAIL load_stage: got %0d want 1", stage_num); end
        n_cmp++; if (stage_resetN !== 1'b0) begin n_bad++; $display("FAIL load_srn_c1: got %0b want 0", stage_resetN); end
        start_key = 1'b0;
        died = 1'b1;          // kills in LOAD must not score
        q_score.push_back(0);
        tick();
        n_cmp++; if (stage_resetN !== 1'b0) begin n_bad++; $display("FAIL load_srn_c2: got %0b want 0", stage_resetN); end
        tick();
        died = 1'b0;
        n_cmp++; if (stage_resetN !== 1'b1) begin n_bad++; $display("FAIL load_srn_c3: got %0b want 1", stage_resetN); end
        exp = q_score.pop_front();
        n_cmp++; if (score !== 12'(exp)) begin n_bad++; $display("FAIL load_score: got %0d want %0d", score, exp); end
        tick();
        n_cmp++; if (enable !== 1'b0) begin n_bad++; $display("FAIL load_enable: got %0b want 0", enable); end
        pulse_sof();
        n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL play_enable: got %0b want 1", enable); end
    endtask

    task automatic test_stage_advance();
        amd = 1'b1;
        tick(); tick();
        n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL unarmed_amd: got enable=%0b want 1", enable); end
        pulse_sof();          // arms; same-cycle amd still ignored
        n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL arm_cycle: got enable=%0b want 1", enable); end
        tick();
        amd = 1'b0;
        n_cmp++; if (enable !== 1'b0) begin n_bad++; $display("FAIL clear_enable: got %0b want 0", enable); end
        for (int i = 0; i < 59; i++) begin
            tick();
            pulse_sof();
        end
        n_cmp++; if (stage_num !== 3'd1 || stage_resetN !== 1'b1) begin n_bad++; $display("FAIL clear_59: got stage=%0d srn=%0b want 1/1", stage_num, stage_resetN); end
        tick();
        pulse_sof();
        n_cmp++; if (stage_num !== 3'd2 || stage_resetN !== 1'b0) begin n_bad++; $display("FAIL clear_60: got stage=%0d srn=%0b want 2/0", stage_num, stage_resetN); end
        tick(); tick();
        n_cmp++; if (stage_resetN !== 1'b1) begin n_bad++; $display("FAIL stage2_srn: got %0b want 1", stage_resetN); end
        pulse_sof();
        n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL stage2_play: got %0b want 1", enable); end
    endtask

    task automatic test_score();
        int exp;
        m_score = 0;
        for (int k = 0; k < 3; k++) begin
            died = 1'b1;
            m_score += 10;
            q_score.push_back(m_score);
            tick();
            died = 1'b0;
            exp = q_score.pop_front();
            n_cmp++; if (score !== 12'(exp)) begin n_bad++; $display("FAIL kill_%0d: got %0d want %0d", k, score, exp); end
            tick();
        end
        for (int k = 0; k < 410; k++) begin
            died = 1'b1;
            m_score = (m_score + 10 > 4095) ? 4095 : m_score + 10;
            q_score.push_back(m_score);
            tick();
            exp = q_score.pop_front();
            n_cmp++; if (score !== 12'(exp)) begin n_bad++; $display("FAIL sat_%0d: got %0d want %0d", k, score, exp); end
        end
        died = 1'b0;
        n_cmp++; if (score !== 12'd4095) begin n_bad++; $display("FAIL sat_final: got %0d want 4095", score); end
    endtask

    task automatic test_win();
        for (int s = 2; s <= 4; s++) begin
            play_and_clear();
            if (s < 4) begin
                n_cmp++; if (stage_num !== 3'(s + 1) || stage_resetN !== 1'b0) begin n_bad++; $display("FAIL advance_%0d: got stage=%0d srn=%0b want %0d/0", s, stage_num, stage_resetN, s + 1); end
                tick(); tick();
                pulse_sof();
            end
        end
        n_cmp++; if (game_won !== 1'b1 || stage_num !== 3'd4) begin n_bad++; $display("FAIL won: got won=%0b stage=%0d want 1/4", game_won, stage_num); end
        n_cmp++; if (enable !== 1'b0 || score !== 12'd4095) begin n_bad++; $display("FAIL won_hold: got en=%0b score=%0d want 0/4095", enable, score); end
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        n_cmp++; if (stage_num !== 3'd0 || game_won !== 1'b0) begin n_bad++; $display("FAIL won_to_idle: got stage=%0d won=%0b want 0/0", stage_num, game_won); end
        tick();
    endtask

    task automatic test_midgame_reset();
        start_key = 1'b1; tick(); start_key = 1'b0;
        tick(); tick();
        pulse_sof();
        died = 1'b1; tick(); died = 1'b0;
        n_cmp++; if (score !== 12'd10) begin n_bad++; $display("FAIL mid_score: got %0d want 10", score); end
        #2 resetN = 1'b0;
        #1;
        n_cmp++; if (stage_num !== 3'd0 || enable !== 1'b0 || score !== 12'd0 || stage_resetN !== 1'b1) begin n_bad++; $display("FAIL async_reset: got stage=%0d en=%0b score=%0d srn=%0b want 0/0/0/1", stage_num, enable, score, stage_resetN); end
        tick();
        resetN = 1'b1;
        tick();
        n_cmp++; if (stage_resetN !== 1'b1 || stage_num !== 3'd0) begin n_bad++; $display("FAIL post_reset: got srn=%0b stage=%0d want 1/0", stage_resetN, stage_num); end
    endtask

    task automatic test_priority();
        start_key = 1'b1; tick(); start_key = 1'b0;
        tick(); tick();
        pulse_sof();
        pulse_sof();
        amd = 1'b1; pd = 1'b1;
        tick();
        amd = 1'b0; pd = 1'b0;
`ifdef GAME_STAGE_CONTROLLER_LIVES_EN
        n_cmp++; if (stage_resetN !== 1'b0 || lives !== 2'd2 || game_over !== 1'b0) begin n_bad++; $display("FAIL priority: got srn=%0b lives=%0d over=%0b want 0/2/0", stage_resetN, lives, game_over); end
`else
        n_cmp++; if (game_over !== 1'b1 || enable !== 1'b0 || stage_num !== 3'd1) begin n_bad++; $display("FAIL priority: got over=%0b en=%0b stage=%0d want 1/0/1", game_over, enable, stage_num); end
        n_cmp++; if (lives !== 2'd1) begin n_bad++; $display("FAIL fixed_lives: got %0d want 1", lives); end
`endif
        tick();
    endtask

`ifdef GAME_STAGE_CONTROLLER_LIVES_EN
    task automatic test_lives();
        int exp;
        resetN = 1'b0; tick(); resetN = 1'b1; tick();
        start_key = 1'b1; tick(); start_key = 1'b0;
        tick(); tick();
        pulse_sof();
        play_and_clear();
        tick(); tick();
        pulse_sof();
        m_score = 10;
        died = 1'b1; q_score.push_back(m_score); tick(); died = 1'b0;
        exp = q_score.pop_front();
        n_cmp++; if (score !== 12'(exp)) begin n_bad++; $display("FAIL lives_kill: got %0d want %0d", score, exp); end
        for (int d = 1; d <= 3; d++) begin
            pd = 1'b1; tick(); pd = 1'b0;
            if (d < 3) begin
                n_cmp++; if (lives !== 2'(3 - d) || stage_num !== 3'd2 || stage_resetN !== 1'b0 || score !== 12'(m_score)) begin n_bad++; $display("FAIL death_%0d: got lives=%0d stage=%0d srn=%0b score=%0d want %0d/2/0/%0d", d, lives, stage_num, stage_resetN, score, 3 - d, m_score); end
                tick(); tick();
                pulse_sof();
            end else begin
                n_cmp++; if (lives !== 2'd0 || game_over !== 1'b1 || stage_num !== 3'd2) begin n_bad++; $display("FAIL death_last: got lives=%0d over=%0b stage=%0d want 0/1/2", lives, game_over, stage_num); end
            end
        end
    endtask
`endif

    initial begin
        resetN = 1'b0; sof = 1'b0; start_key = 1'b0;
        amd = 1'b0; died = 1'b0; pd = 1'b0;
        test_reset();
        test_start_load();
        test_stage_advance();
        test_score();
        test_win();
        test_midgame_reset();
        test_priority();
`ifdef GAME_STAGE_CONTROLLER_LIVES_EN
        test_lives();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
